// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding AXI4 instruction fetch stage with stall hold and flush discard.
module inst_fetch #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 28
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        STALL,
  input  logic                        FLUSH,
  input  logic [31:0]                 PC,
  input  logic                        PC_VALID,
  output logic                        PC_READY,
  output logic [31:0]                 INST,
  output logic [31:0]                 INST_PC,
  output logic                        INST_VALID,
  output logic                        INST_ERR,
  output logic                        INST_MEM_WAIT,
  output logic [C_OFFSET_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_e;
  state_e                    state_q;
  logic [31:0]               inst_q, inst_pc_q;
  logic [C_OFFSET_WIDTH-1:0] araddr_q;
  logic                      valid_q, err_q, wait_q, arvalid_q, rready_q, perr_q, discard_q;
  logic                      accept_d, drop_d;
  assign PC_READY      = !FLUSH && (state_q == IDLE || (state_q == HOLD && !STALL));
  assign accept_d      = PC_VALID && PC_READY;
  assign drop_d        = discard_q || FLUSH;
  assign INST          = inst_q;
  assign INST_PC       = inst_pc_q;
  assign INST_VALID    = valid_q;
  assign INST_ERR      = err_q;
  assign INST_MEM_WAIT = wait_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      inst_pc_q <= '0;
      araddr_q  <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      wait_q    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      perr_q    <= 1'b0;
      discard_q <= 1'b0;
    end else if (accept_d) begin
      state_q   <= ADDR;
      inst_pc_q <= PC;
      araddr_q  <= {PC[C_OFFSET_WIDTH-1:2], 2'b00};
      arvalid_q <= 1'b1;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      perr_q    <= |PC[1:0];
      wait_q    <= 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          // AR must complete even when flushed; only the response is dropped
          if (FLUSH) discard_q <= 1'b1;
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (FLUSH) discard_q <= 1'b1;
          if (M_AXI_RVALID && M_AXI_RLAST) begin
            rready_q  <= 1'b0;
            wait_q    <= 1'b0;
            discard_q <= 1'b0;
            valid_q   <= !drop_d;
            state_q   <= drop_d ? IDLE : HOLD;
            if (!drop_d) begin
              inst_q <= M_AXI_RDATA[31:0];
              err_q  <= perr_q | (|M_AXI_RRESP);
            end
          end
        end
        HOLD: begin
          if (FLUSH || !STALL) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a randomized AXI slave and a memory-table model.
module tb_inst_fetch;
  logic        CLK = 1'b0;
  logic        RST, STALL, FLUSH, PC_VALID, PC_READY;
  logic [31:0] PC, INST, INST_PC, RDATA;
  logic        INST_VALID, INST_ERR, INST_MEM_WAIT;
  logic [27:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, RRESP;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;

  inst_fetch #(.C_AXI_DATA_WIDTH(32), .C_OFFSET_WIDTH(28)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .PC(PC), .PC_VALID(PC_VALID),
    .PC_READY(PC_READY), .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID),
    .INST_ERR(INST_ERR), .INST_MEM_WAIT(INST_MEM_WAIT), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST),
    .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA),
    .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem[256];
  logic [1:0]  rsp[256];
  logic [27:0] last_addr = '0;
  logic [27:0] cap = '0;
  int          total = 0, bad = 0;
  int          ar_lo = 0, ar_hi = 0, r_lo = 0, r_hi = 0;
  int          sst = 0, ar_cnt = 0, r_cnt = 0;

  function automatic exp_t model(logic [31:0] pc);
    exp_t e;
    e.inst = mem[pc[9:2]];
    e.pc   = pc;
    e.err  = (pc[1:0] != 2'b00) || (rsp[pc[9:2]] != 2'b00);
    return e;
  endfunction

  task automatic chk(string n, logic [95:0] act, logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask

  task automatic fetch(logic [31:0] p);
    PC = p;
    PC_VALID = 1'b1;
    @(posedge CLK); #1;
    PC_VALID = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!INST_VALID && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("wait_valid", {95'd0, INST_VALID}, 96'd1);
  endtask

  // Scoreboard push: decisions for the coming edge are settled by mid-cycle
  initial forever begin
    @(posedge CLK); #5;
    if (RST) begin
      if (PC_VALID && PC_READY) begin
        q.push_back(model(PC));
        last_addr = {PC[27:2], 2'b00};
      end else if (FLUSH && q.size() > 0) begin
        void'(q.pop_back());
      end
    end
  end

  // Monitor: a presented word is checked every cycle and retired when consumed
  initial forever begin
    @(negedge CLK);
    if (RST && INST_VALID && !FLUSH) begin
      if (q.size() == 0) chk("unexpected_inst", {95'd0, INST_VALID}, 96'd0);
      else begin
        chk("inst_word", {31'd0, INST, INST_PC, INST_ERR}, {31'd0, q[0]});
        if (!STALL) void'(q.pop_front());
      end
    end
  end

  // AXI slave with configurable AR and R delays
  initial begin
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = '0;
    forever begin
      @(posedge CLK); #1;
      if (!RST) begin
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; sst = 0;
      end else if (sst == 3) begin
        RVALID = 1'b0; RLAST = 1'b0; sst = 0;
      end else if (sst == 2) begin
        ARREADY = 1'b0;
        chk("rready_in_data", {95'd0, RREADY}, 96'd1);
        if (r_cnt == 0) begin
          RVALID = 1'b1; RLAST = 1'b1;
          RDATA = mem[cap[9:2]]; RRESP = rsp[cap[9:2]];
          sst = 3;
        end else r_cnt--;
      end else begin
        if (sst == 0 && ARVALID) begin
          ar_cnt = $urandom_range(ar_hi, ar_lo);
          r_cnt  = $urandom_range(r_hi, r_lo);
          sst = 1;
        end
        if (sst == 1) begin
          chk("araddr", {68'd0, ARADDR}, {68'd0, last_addr});
          chk("arvalid_held", {95'd0, ARVALID}, 96'd1);
          if (ar_cnt == 0) begin
            ARREADY = 1'b1;
            cap = ARADDR;
            chk("ar_const", {83'd0, ARLEN, ARSIZE, ARBURST}, {83'd0, 8'd0, 3'b010, 2'b01});
            sst = 2;
          end else ar_cnt--;
        end
      end
    end
  end

  initial begin
    int it, cnt;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      rsp[i] = ($urandom % 8 == 0) ? 2'(1 + $urandom % 3) : 2'b00;
    end
    mem[0] = 32'h0000_0013;  rsp[0] = 2'b00;
    mem[1] = 32'h0000_0113;  rsp[1] = 2'b00;
    mem[2] = 32'h0050_0093;  rsp[2] = 2'b00;
    mem[4] = 32'h0000_0213;  rsp[4] = 2'b00;
    mem[8] = 32'h0000_0413;  rsp[8] = 2'b10;
    mem[12] = 32'h0000_0613; rsp[12] = 2'b00;
    mem[16] = 32'hDEAD_BEEF; rsp[16] = 2'b00;
    mem[64] = 32'h1234_5678; rsp[64] = 2'b00;
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; PC = '0; PC_VALID = 1'b0;
    #3 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_ctl", {91'd0, ARVALID, RREADY, INST_VALID, INST_ERR, INST_MEM_WAIT}, 96'd0);
    chk("reset_inst", {32'd0, INST, INST_PC}, 96'd0);
    chk("reset_addr", {68'd0, ARADDR}, 96'd0);
    chk("reset_const", {83'd0, ARLEN, ARSIZE, ARBURST}, {83'd0, 8'd0, 3'b010, 2'b01});
    RST = 1'b1;
    // minimum-latency fetch
    PC = 32'h0; PC_VALID = 1'b1;
    #1 chk("ready_idle", {95'd0, PC_READY}, 96'd1);
    @(posedge CLK); #1;
    PC_VALID = 1'b0;
    chk("lat_n1", {66'd0, ARVALID, INST_MEM_WAIT, ARADDR}, {66'd0, 1'b1, 1'b1, 28'h0});
    @(posedge CLK); #1;
    chk("lat_n2", {93'd0, INST_MEM_WAIT, RREADY, INST_VALID}, {93'd0, 3'b110});
    @(posedge CLK); #1;
    chk("lat_n3", {30'd0, INST_VALID, INST_MEM_WAIT, INST, INST_PC}, {30'd0, 1'b1, 1'b0, 32'h13, 32'h0});
    // stall hold, then accept on release
    fetch(32'h8);
    STALL = 1'b1; PC = 32'h4; PC_VALID = 1'b1;
    wait_valid();
    repeat (5) begin
      chk("stall_hold", {31'd0, INST_VALID, INST, INST_PC}, {31'd0, 1'b1, 32'h0050_0093, 32'h8});
      chk("stall_ready", {95'd0, PC_READY}, 96'd0);
      @(posedge CLK); #1;
    end
    STALL = 1'b0;
    #1 chk("unstall_ready", {95'd0, PC_READY}, 96'd1);
    @(posedge CLK); #1;
    PC_VALID = 1'b0;
    chk("next_addr", {67'd0, ARVALID, ARADDR}, {67'd0, 1'b1, 28'h4});
    wait_valid();
    // slow slave
    ar_lo = 3; ar_hi = 3; r_lo = 4; r_hi = 4;
    fetch(32'h10);
    it = 0; cnt = 0;
    while (!INST_VALID && it < 60) begin
      it++;
      if (INST_MEM_WAIT) cnt++;
      @(posedge CLK); #1;
    end
    chk("wait_len", {95'd0, (cnt >= 7) && (cnt == it)}, 96'd1);
    chk("slow_valid", {95'd0, INST_VALID}, 96'd1);
    // flush while in DATA
    ar_lo = 0; ar_hi = 0; r_lo = 2; r_hi = 2;
    fetch(32'h40);
    @(posedge CLK); #1;
    chk("flush_in_data", {95'd0, RREADY}, 96'd1);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("flush_novalid", {95'd0, INST_VALID}, 96'd0);
      chk("flush_ready", {95'd0, PC_READY}, {95'd0, i == 2});
      if (i < 2) begin
        @(posedge CLK); #2;
      end
    end
    r_lo = 0; r_hi = 0;
    fetch(32'h100);
    wait_valid();
    // error cases
    fetch(32'h6);
    wait_valid();
    chk("misalign_err", {67'd0, INST_ERR, ARADDR}, {67'd0, 1'b1, 28'h4});
    fetch(32'h20);
    wait_valid();
    chk("rresp_err", {95'd0, INST_ERR}, 96'd1);
    // asynchronous reset in DATA
    r_lo = 5; r_hi = 5;
    fetch(32'h30);
    it = 0;
    while (!RREADY && it < 20) begin
      it++;
      @(posedge CLK); #1;
    end
    chk("in_data", {95'd0, RREADY}, 96'd1);
    #3 RST = 1'b0;
    #1 chk("async_rst", {92'd0, ARVALID, RREADY, INST_VALID, INST_MEM_WAIT}, 96'd0);
    q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    r_lo = 0; r_hi = 0;
    fetch(32'h8);
    wait_valid();
    // randomized traffic
    ar_hi = 3; r_hi = 3;
    repeat (400) begin
      PC_VALID = ($urandom % 10) < 7;
      PC = $urandom;
      if ($urandom % 10 != 0) PC[1:0] = 2'b00;
      STALL = ($urandom % 10) < 3;
      FLUSH = ($urandom % 20) == 0;
      @(posedge CLK); #1;
    end
    PC_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("drain", 96'(q.size()), 96'd0);
    chk("final_ready", {95'd0, PC_READY}, 96'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
